// File: rtl/mcu_spi.sv
// mcu_spi: SPI mode-0 slave bridging the IO MCU to the hid/osd/sdc targets.
// Pins are oversampled on clk. Byte 0 of each chip-select frame picks the
// target, byte 1 is the command (data_start=1), and later bytes are payload.
// Handshake: a target strobe is a one-cycle valid with no ready; data_out and
// data_start are stable in the strobe cycle and held until the next strobe.
module mcu_spi #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  VERSION     = 8'h5c
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_ss_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] data_out,
    output logic       data_start,
    output logic       hid_strobe,
    output logic       osd_strobe,
    output logic       sdc_strobe,
    input  logic [7:0] hid_din,
    input  logic [7:0] osd_din,
    input  logic [7:0] sdc_din,
    input  logic       hid_irq,
    input  logic       sdc_irq,
    output logic       hid_iack,
    output logic       sdc_iack,
    output logic       irq_n
);

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic       ss_prev, sclk_prev;
    logic       ss_s, sclk_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic       frame_active;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;
    logic [7:0] rx_sr;
    logic [7:0] rx_next;
    logic [7:0] tx_sr;
    logic [7:0] target;

    logic       done_q;
    logic [7:0] done_byte;
    logic [1:0] done_idx;
    logic       load_q;
    logic [1:0] load_idx;
    logic       cmd_zero;
    logic       ver_next;
    logic [1:0] status;
    logic [7:0] load_val;
    logic       tgt_routed;

    // Synchronisers are deliberately not reset: they keep tracking the pins
    // during reset, so releasing reset mid-frame cannot fabricate an edge.
    always_ff @(posedge clk) begin
        ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        ss_prev   <= ss_sync[SYNC_STAGES-1];
        sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ~ss_s & ss_prev;
    assign ss_rise   = ss_s & ~ss_prev;
    assign rx_next   = {rx_sr[6:0], mosi_s};
    assign tgt_routed = (target == 8'd1) || (target == 8'd2) || (target == 8'd3);
    assign spi_miso  = tx_sr[7];

    // Reply byte for the next MISO byte, chosen by which byte just completed.
    always_comb begin
        load_val = 8'h00;
        if (load_idx != 2'd0) begin
            case (target)
                8'd1:    load_val = hid_din;
                8'd2:    load_val = osd_din;
                8'd3:    load_val = sdc_din;
                8'd0: begin
                    if (load_idx == 2'd1)
                        load_val = cmd_zero ? {6'b0, status} : 8'h00;
                    else
                        load_val = ver_next ? VERSION : 8'h00;
                end
                default: load_val = 8'h00;
            endcase
        end
    end

    // Frame deframing, byte routing, MISO shifting and irq aggregation.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_active <= 1'b0;
            bit_cnt      <= 3'd0;
            byte_idx     <= 2'd0;
            rx_sr        <= 8'h00;
            tx_sr        <= 8'h00;
            target       <= 8'h00;
            done_q       <= 1'b0;
            done_byte    <= 8'h00;
            done_idx     <= 2'd0;
            load_q       <= 1'b0;
            load_idx     <= 2'd0;
            cmd_zero     <= 1'b0;
            ver_next     <= 1'b0;
            status       <= 2'b00;
            data_out     <= 8'h00;
            data_start   <= 1'b0;
            hid_strobe   <= 1'b0;
            osd_strobe   <= 1'b0;
            sdc_strobe   <= 1'b0;
            hid_iack     <= 1'b0;
            sdc_iack     <= 1'b0;
            irq_n        <= 1'b1;
        end else begin
            irq_n      <= ~(hid_irq | sdc_irq);
            hid_strobe <= 1'b0;
            osd_strobe <= 1'b0;
            sdc_strobe <= 1'b0;
            hid_iack   <= 1'b0;
            sdc_iack   <= 1'b0;
            done_q     <= 1'b0;
            load_q     <= done_q;
            load_idx   <= done_idx;

            // Act on the byte completed last cycle.
            if (done_q) begin
                case (done_idx)
                    2'd0: begin
                        target   <= done_byte;
                        cmd_zero <= 1'b0;
                    end
                    2'd1: begin
                        if (tgt_routed) begin
                            data_out   <= done_byte;
                            data_start <= 1'b1;
                        end
                        hid_strobe <= (target == 8'd1);
                        osd_strobe <= (target == 8'd2);
                        sdc_strobe <= (target == 8'd3);
                        if (target == 8'd0 && done_byte == 8'h00) begin
                            cmd_zero <= 1'b1;
                            status   <= {sdc_irq, hid_irq};
                            hid_iack <= hid_irq;
                            sdc_iack <= sdc_irq;
                        end
                    end
                    default: begin
                        if (tgt_routed) begin
                            data_out   <= done_byte;
                            data_start <= 1'b0;
                        end
                        hid_strobe <= (target == 8'd1);
                        osd_strobe <= (target == 8'd2);
                        sdc_strobe <= (target == 8'd3);
                    end
                endcase
            end

            if (ss_fall) begin
                frame_active <= 1'b1;
                bit_cnt      <= 3'd0;
                byte_idx     <= 2'd0;
                tx_sr        <= 8'h00;
            end else if (ss_rise) begin
                frame_active <= 1'b0;
                bit_cnt      <= 3'd0;
                byte_idx     <= 2'd0;
                tx_sr        <= 8'h00;
                load_q       <= 1'b0;
            end else if (frame_active && !ss_s) begin
                if (sclk_rise) begin
                    rx_sr   <= rx_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        done_q    <= 1'b1;
                        done_byte <= rx_next;
                        done_idx  <= byte_idx;
                        if (byte_idx != 2'd2)
                            byte_idx <= byte_idx + 2'd1;
                    end
                end
                if (sclk_fall && bit_cnt != 3'd0)
                    tx_sr <= {tx_sr[6:0], 1'b0};
                if (load_q) begin
                    tx_sr <= load_val;
                    if (target == 8'd0 && load_idx == 2'd1)
                        ver_next <= cmd_zero;
                    else if (load_idx == 2'd2)
                        ver_next <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_spi.sv
// tb_mcu_spi: directed frames against mcu_spi with hand-computed strobe and
// MISO expectations; strobes are scoreboarded through an expected queue.
`timescale 1ns/1ps
module tb_mcu_spi;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_ss_n, spi_sclk, spi_mosi;
    logic       spi_miso;
    logic [7:0] data_out;
    logic       data_start;
    logic       hid_strobe, osd_strobe, sdc_strobe;
    logic [7:0] hid_din, osd_din, sdc_din;
    logic       hid_irq, sdc_irq;
    logic       hid_iack, sdc_iack;
    logic       irq_n;

    int vec_cnt = 0;
    int err_cnt = 0;
    int hid_iack_cnt = 0;
    int sdc_iack_cnt = 0;
    logic [10:0] exp_q[$];
    logic [31:0] rx;

    mcu_spi dut (
        .clk(clk), .reset(reset),
        .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .data_out(data_out), .data_start(data_start),
        .hid_strobe(hid_strobe), .osd_strobe(osd_strobe), .sdc_strobe(sdc_strobe),
        .hid_din(hid_din), .osd_din(osd_din), .sdc_din(sdc_din),
        .hid_irq(hid_irq), .sdc_irq(sdc_irq),
        .hid_iack(hid_iack), .sdc_iack(sdc_iack), .irq_n(irq_n)
    );

    // 32 MHz system clock
    always #15.625 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [1:0] tgt, input logic st, input logic [7:0] d);
        return {tgt, st, d};
    endfunction

    // Strobe scoreboard: every strobe must match the head of exp_q.
    always @(negedge clk) begin
        if (!reset) begin
            if (hid_strobe || osd_strobe || sdc_strobe) begin
                logic [10:0] got;
                logic [1:0]  t;
                t = hid_strobe ? 2'd1 : (osd_strobe ? 2'd2 : 2'd3);
                got = {t, data_start, data_out};
                check("strobe_onehot", 32'(hid_strobe) + 32'(osd_strobe) + 32'(sdc_strobe), 32'd1);
                if (exp_q.size() == 0)
                    check("unexpected_strobe", {21'd0, got}, 32'd0);
                else
                    check("strobe", {21'd0, got}, {21'd0, exp_q.pop_front()});
            end
            if (hid_iack) hid_iack_cnt++;
            if (sdc_iack) sdc_iack_cnt++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: MISO is sampled just before the rising edge.
    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        wait_clks(16);
        r = spi_miso;
        spi_sclk = 1'b1;
        wait_clks(16);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rb);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rb[i] = b;
        end
    endtask

    task automatic ss_begin();
        spi_ss_n = 1'b0;
        wait_clks(16);
    endtask

    task automatic ss_end();
        wait_clks(16);
        spi_ss_n = 1'b1;
        wait_clks(24);
    endtask

    // Full frame of n bytes; byte 0 in bytes[31:24], replies in rb likewise.
    task automatic send_frame(input logic [31:0] bytes, input int n, output logic [31:0] rb);
        logic [7:0] r;
        rb = 32'h0;
        ss_begin();
        for (int k = 0; k < n; k++) begin
            spi_byte(bytes[31-8*k -: 8], r);
            rb[31-8*k -: 8] = r;
        end
        ss_end();
    endtask

    initial begin
        logic [7:0] r;
        logic b;
        reset = 1'b1; spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        hid_din = 8'ha7; osd_din = 8'h6e; sdc_din = 8'hc3;
        hid_irq = 1'b0; sdc_irq = 1'b0;
        wait_clks(8);
        reset = 1'b0;
        wait_clks(4);

        // Reset state
        check("rst_miso", spi_miso, 0);
        check("rst_data_out", data_out, 0);
        check("rst_start", data_start, 0);
        check("rst_strobes", {hid_strobe, osd_strobe, sdc_strobe}, 0);
        check("rst_iacks", {hid_iack, sdc_iack}, 0);
        check("rst_irq_n", irq_n, 1);

        // Frame 01 01 95 to hid
        exp_q.push_back(mk(2'd1, 1'b1, 8'h01));
        exp_q.push_back(mk(2'd1, 1'b0, 8'h95));
        send_frame(32'h01019500, 3, rx);
        check("f1_rx", rx[31:8], 24'h0000a7);
        check("f1_left", exp_q.size(), 0);
        check("f1_miso_idle", spi_miso, 0);

        // hid_din=5c after cmd 00
        hid_din = 8'h5c;
        exp_q.push_back(mk(2'd1, 1'b1, 8'h00));
        exp_q.push_back(mk(2'd1, 1'b0, 8'h3a));
        send_frame(32'h01003a00, 3, rx);
        check("f2_rx", rx[31:8], 24'h00005c);
        check("f2_left", exp_q.size(), 0);

        // System status frame with hid_irq pending
        hid_irq = 1'b1;
        wait_clks(4);
        check("irq_n_low", irq_n, 0);
        hid_iack_cnt = 0; sdc_iack_cnt = 0;
        send_frame(32'h0000aabb, 4, rx);
        check("f3_rx", rx, 32'h0000015c);
        check("f3_hid_iack", hid_iack_cnt, 1);
        check("f3_sdc_iack", sdc_iack_cnt, 0);
        check("f3_data_held", {data_start, data_out}, 9'h03a);

        // Only sdc pending
        hid_irq = 1'b0; sdc_irq = 1'b1;
        hid_iack_cnt = 0; sdc_iack_cnt = 0;
        send_frame(32'h00001122, 4, rx);
        check("f4_rx", rx, 32'h0000025c);
        check("f4_iacks", {hid_iack_cnt[7:0], sdc_iack_cnt[7:0]}, 16'h0001);
        sdc_irq = 1'b0;
        wait_clks(4);
        check("irq_n_high", irq_n, 1);

        // Aborted frame: 01 33 then 5 bits of byte 2
        exp_q.push_back(mk(2'd1, 1'b1, 8'h33));
        ss_begin();
        spi_byte(8'h01, r);
        spi_byte(8'h33, r);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        ss_end();
        check("abort_left", exp_q.size(), 0);
        check("abort_miso", spi_miso, 0);
        exp_q.push_back(mk(2'd2, 1'b1, 8'h07));
        send_frame(32'h02070000, 2, rx);
        check("f5_left", exp_q.size(), 0);
        check("f5_data", {data_start, data_out}, 9'h107);

        // Unrouted target 05, then sdc
        send_frame(32'h05a1b2c3, 4, rx);
        check("f6_rx", rx, 32'h0);
        check("f6_data_held", {data_start, data_out}, 9'h107);
        exp_q.push_back(mk(2'd3, 1'b1, 8'h44));
        exp_q.push_back(mk(2'd3, 1'b0, 8'h55));
        send_frame(32'h03445500, 3, rx);
        check("f7_rx", rx[31:8], 24'h0000c3);
        check("f7_left", exp_q.size(), 0);

        // Reset mid-byte, with hid_irq pending
        hid_irq = 1'b1;
        ss_begin();
        spi_byte(8'h01, r);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
        reset = 1'b1;
        wait_clks(3);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_start", data_start, 0);
        check("mid_rst_irq_n", irq_n, 1);
        check("mid_rst_miso", spi_miso, 0);
        reset = 1'b0;
        hid_irq = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'b0, b);
        spi_byte(8'h99, r);
        ss_end();
        check("post_rst_quiet", exp_q.size(), 0);
        check("post_rst_data", data_out, 0);
        exp_q.push_back(mk(2'd2, 1'b1, 8'h11));
        exp_q.push_back(mk(2'd2, 1'b0, 8'h22));
        send_frame(32'h02112200, 3, rx);
        check("f8_rx", rx[31:8], 24'h00006e);
        check("f8_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
